mod_updown_counter: RTL and testbench

- Parametrised modulo-N up/down counter with synchronous load and a synchronised, edge-detected count-enable input.
- Next-generation building block for the clock datapath: seconds, minutes and hours digits, and cascaded BCD stages.
- Cascading is done through the single-cycle `carry`/`borrow` pulses, fed into the next stage's `clken`.
- Adds over the previous counter:
  - width/modulo parameters
  - down-counting with wrap
  - load saturation
  - terminal-count decode
  - a fully synchronous reset

---
 rtl/clock_defs_pkg.sv | 11 +
 rtl/edge_pulse_sync.sv | 19 +
 rtl/mod_updown_counter.sv | 56 +++++
 tb/tb_mod_updown_counter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_defs_pkg.sv
// clock_defs: shared moduli and widths for the clock datapath counters
package clock_defs;
  localparam int MOD_SEC  = 60;
  localparam int MOD_MIN  = 60;
  localparam int MOD_HOUR = 24;
  localparam int MOD_BCD  = 10;
  localparam int W_SEC    = 6;
  localparam int W_MIN    = 6;
  localparam int W_HOUR   = 5;
  localparam int W_BCD    = 4;
endpackage

// File: rtl/edge_pulse_sync.sv
// edge_pulse_sync: 2-FF synchroniser turning each rising edge of an async input into a one-cycle pulse
module edge_pulse_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);
  logic s1, s2, valid, armed;
  // armed only after a genuine low sample, so an input still high out of reset never pulses
  always_ff @(posedge clk)
    if (reset) {s1, s2, valid, armed, pulse} <= '0;
    else begin
      s1 <= async_in;
      s2 <= s1;
      valid <= 1'b1;
      armed <= armed | (valid & ~s1);
      pulse <= s1 & ~s2 & armed;
    end
endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo-N up/down counter with saturating load and carry/borrow cascade pulses
module mod_updown_counter
  import clock_defs::*;
#(
  parameter int WIDTH     = W_BCD,
  parameter int MODULO    = MOD_BCD,
  parameter int EDGE_SYNC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clken,
  input  logic             loaden,
  input  logic [WIDTH-1:0] load,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] countout,
  output logic             carry,
  output logic             borrow,
  output logic             at_max,
  output logic             at_zero
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);
  logic step, inc, dec, carry_d, borrow_d;
  logic [WIDTH-1:0] sat, cnt_d;
  generate
    if (EDGE_SYNC != 0) begin : g_sync
      edge_pulse_sync u_sync (.clk(clk), .reset(reset), .async_in(clken), .pulse(step));
    end else begin : g_direct
      assign step = clken;
    end
  endgenerate
  assign at_max  = countout == MAX;
  assign at_zero = countout == '0;
  assign sat     = (32'(load) >= MODULO) ? MAX : load;
  // load consumes any coincident step; wraps compare against MODULO-1, not natural overflow
  always_comb begin
    inc      = step & up & ~down & ~loaden;
    dec      = step & down & ~up & ~loaden;
    carry_d  = inc & at_max;
    borrow_d = dec & at_zero;
    cnt_d    = loaden ? sat :
               inc    ? (at_max ? '0 : countout + 1'b1) :
               dec    ? (at_zero ? MAX : countout - 1'b1) : countout;
  end
  // count register and single-cycle wrap pulses
  always_ff @(posedge clk)
    if (reset) begin
      countout <= '0;
      carry <= 1'b0;
      borrow <= 1'b0;
    end else begin
      countout <= cnt_d;
      carry <= carry_d;
      borrow <= borrow_d;
    end
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: directed and random checks of the modulo counter against an arithmetic model
module tb_mod_updown_counter;
  logic clk = 1'b0, reset = 1'b1;
  logic a_clken = 0, a_loaden = 0, a_up = 0, a_down = 0;
  logic [3:0] a_load = 0, a_count;
  logic a_carry, a_borrow, a_max, a_zero;
  logic b_clken = 0, b_loaden = 0, b_up = 0, b_down = 0;
  logic [5:0] b_load = 0, b_count;
  logic b_carry, b_borrow, b_max, b_zero;
  logic c_clken = 0;
  logic [3:0] c1_count;
  logic [2:0] c2_count;
  logic c1_carry, c1_borrow, c1_max, c1_zero, c2_carry, c2_borrow, c2_max, c2_zero;
  int errors = 0, checks = 0;
  int a_cnt, b_cnt, c1_cnt, c2_cnt;
  bit a_car, a_bor, b_car, b_bor, c1_car, c1_bor, c2_car, c2_bor;
  bit a_last, a_r1, a_r2;
  int carries, carry_at, carry_j;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MODULO(10), .EDGE_SYNC(1)) u_a (
    .clk(clk), .reset(reset), .clken(a_clken), .loaden(a_loaden), .load(a_load), .up(a_up), .down(a_down),
    .countout(a_count), .carry(a_carry), .borrow(a_borrow), .at_max(a_max), .at_zero(a_zero));
  mod_updown_counter #(.WIDTH(6), .MODULO(60), .EDGE_SYNC(0)) u_b (
    .clk(clk), .reset(reset), .clken(b_clken), .loaden(b_loaden), .load(b_load), .up(b_up), .down(b_down),
    .countout(b_count), .carry(b_carry), .borrow(b_borrow), .at_max(b_max), .at_zero(b_zero));
  mod_updown_counter #(.WIDTH(4), .MODULO(10), .EDGE_SYNC(0)) u_c1 (
    .clk(clk), .reset(reset), .clken(c_clken), .loaden(1'b0), .load(4'd0), .up(1'b1), .down(1'b0),
    .countout(c1_count), .carry(c1_carry), .borrow(c1_borrow), .at_max(c1_max), .at_zero(c1_zero));
  mod_updown_counter #(.WIDTH(3), .MODULO(6), .EDGE_SYNC(0)) u_c2 (
    .clk(clk), .reset(reset), .clken(c1_carry), .loaden(1'b0), .load(3'd0), .up(1'b1), .down(1'b0),
    .countout(c2_count), .carry(c2_carry), .borrow(c2_borrow), .at_max(c2_max), .at_zero(c2_zero));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic nxt(input int m, input bit rst, input bit st, input bit ld, input int ldv,
                     input bit u, input bit d, inout int cnt, output bit car, output bit bor);
    car = 0;
    bor = 0;
    if (rst) cnt = 0;
    else if (ld) cnt = (ldv >= m) ? m - 1 : ldv;
    else if (st && u && !d) begin car = (cnt == m - 1); cnt = (cnt + 1) % m; end
    else if (st && d && !u) begin bor = (cnt == 0); cnt = (cnt + m - 1) % m; end
  endtask

  task automatic chk_inst(input string n, input int m, input logic [31:0] cnt, input logic car, input logic bor,
                          input logic amax, input logic azero, input int mcnt, input bit mcar, input bit mbor);
    check({n, "_count"}, cnt, mcnt);
    check({n, "_carry"}, 32'(car), 32'(mcar));
    check({n, "_borrow"}, 32'(bor), 32'(mbor));
    check({n, "_at_max"}, 32'(amax), 32'(mcnt == m - 1));
    check({n, "_at_zero"}, 32'(azero), 32'(mcnt == 0));
  endtask

  task automatic tick();
    bit c2_st;
    nxt(10, reset, a_r2, a_loaden, int'(a_load), a_up, a_down, a_cnt, a_car, a_bor);
    if (reset) begin a_last = 1; a_r1 = 0; a_r2 = 0; end
    else begin a_r2 = a_r1; a_r1 = a_clken && !a_last; a_last = a_clken; end
    nxt(60, reset, b_clken, b_loaden, int'(b_load), b_up, b_down, b_cnt, b_car, b_bor);
    c2_st = c1_car;
    nxt(10, reset, c_clken, 0, 0, 1, 0, c1_cnt, c1_car, c1_bor);
    nxt(6, reset, c2_st, 0, 0, 1, 0, c2_cnt, c2_car, c2_bor);
    @(posedge clk);
    #1;
    chk_inst("a", 10, 32'(a_count), a_carry, a_borrow, a_max, a_zero, a_cnt, a_car, a_bor);
    chk_inst("b", 60, 32'(b_count), b_carry, b_borrow, b_max, b_zero, b_cnt, b_car, b_bor);
    chk_inst("c1", 10, 32'(c1_count), c1_carry, c1_borrow, c1_max, c1_zero, c1_cnt, c1_car, c1_bor);
    chk_inst("c2", 6, 32'(c2_count), c2_carry, c2_borrow, c2_max, c2_zero, c2_cnt, c2_car, c2_bor);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      a_clken = ~a_clken;
      b_clken = ~b_clken;
      tick();
      check("rst_count", 32'(a_count), 0);
      check("rst_zero", 32'(a_zero), 1);
    end
    reset = 0;
    a_clken = 1;
    b_clken = 0;
    repeat (6) tick();
    check("rst_release_high", 32'(a_count), 0);
    a_clken = 0;
    repeat (3) tick();
    a_up = 1;
    carries = 0;
    carry_at = -1;
    carry_j = -1;
    for (int k = 1; k <= 10; k++) begin
      a_clken = 1;
      for (int j = 0; j < 5; j++) begin
        tick();
        if (a_carry) begin carries++; carry_at = int'(a_count); carry_j = j; end
      end
      a_clken = 0;
      for (int j = 0; j < 5; j++) begin
        tick();
        if (a_carry) carries++;
      end
      check("upwrap_value", 32'(a_count), k % 10);
    end
    check("upwrap_carries", carries, 1);
    check("upwrap_carry_count", carry_at, 0);
    check("upwrap_carry_latency", carry_j, 2);
    a_clken = 1;
    repeat (20) tick();
    a_clken = 0;
    repeat (3) tick();
    check("hold_high_one_step", 32'(a_count), 1);
    b_loaden = 1;
    b_load = 0;
    tick();
    b_loaden = 0;
    b_down = 1;
    b_clken = 1;
    tick();
    check("down_59", 32'(b_count), 59);
    check("down_borrow", 32'(b_borrow), 1);
    tick();
    check("down_58", 32'(b_count), 58);
    check("down_no_borrow", 32'(b_borrow), 0);
    tick();
    check("down_57", 32'(b_count), 57);
    b_clken = 0;
    a_loaden = 1;
    a_load = 12;
    tick();
    a_loaden = 0;
    check("load_sat", 32'(a_count), 9);
    check("load_sat_max", 32'(a_max), 1);
    a_clken = 1;
    tick();
    tick();
    a_loaden = 1;
    a_load = 9;
    tick();
    a_loaden = 0;
    a_clken = 0;
    check("load_vs_step", 32'(a_count), 9);
    check("load_vs_step_carry", 32'(a_carry), 0);
    b_down = 0;
    b_up = 1;
    b_loaden = 1;
    b_load = 59;
    b_clken = 1;
    tick();
    b_loaden = 0;
    check("b_load_vs_step", 32'(b_count), 59);
    check("b_load_vs_step_carry", 32'(b_carry), 0);
    tick();
    check("b_upwrap", 32'(b_count), 0);
    check("b_upwrap_carry", 32'(b_carry), 1);
    a_down = 1;
    b_down = 1;
    for (int k = 0; k < 3; k++) begin
      a_clken = 1;
      repeat (3) tick();
      a_clken = 0;
      repeat (3) tick();
    end
    b_clken = 0;
    check("conflict_a", 32'(a_count), 9);
    check("conflict_b", 32'(b_count), 0);
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 63) == 0);
      a_clken  = 1'($urandom_range(0, 1));
      a_loaden = ($urandom_range(0, 7) == 0);
      a_load   = 4'($urandom_range(0, 15));
      a_up     = 1'($urandom_range(0, 1));
      a_down   = 1'($urandom_range(0, 1));
      b_clken  = 1'($urandom_range(0, 1));
      b_loaden = ($urandom_range(0, 7) == 0);
      b_load   = 6'($urandom_range(0, 63));
      b_up     = 1'($urandom_range(0, 1));
      b_down   = 1'($urandom_range(0, 1));
      tick();
    end
    {a_clken, a_loaden, a_up, a_down, b_clken, b_loaden, b_up, b_down} = '0;
    reset = 1;
    tick();
    reset = 0;
    c_clken = 1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      check("cas_c1", 32'(c1_count), n % 10);
      check("cas_c2", 32'(c2_count), ((n - 1) / 10) % 6);
    end
    c_clken = 0;
    tick();
    check("cas_c1_final", 32'(c1_count), 0);
    check("cas_c2_final", 32'(c2_count), 0);
    check("cas_c2_carry", 32'(c2_carry), 1);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
